// File: rtl/iommu_field_reg_mc.sv
// Purpose: register field with software write port and round-robin arbitrated multi-channel hardware updates.
// Latency: one cycle from accepted write or hardware transfer to q_o; qe_o/upd_o pulse in that same cycle.
// Backpressure: hw_ready_o grants one channel per cycle; in RW/WO modes a software write stalls all channels.

package iommu_field_pkg;
  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessRO,
    SwAccessWO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC,
    SwAccessHW
  } sw_access_e;
endpackage

module iommu_field_reg_mc
  import iommu_field_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_HW     = 2,
  parameter sw_access_e            SwAccess   = SwAccessRW,
  parameter logic [DATA_WIDTH-1:0] RESVAL     = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [DATA_WIDTH-1:0]        wd_i,
  input  logic [NUM_HW-1:0]            hw_valid_i,
  output logic [NUM_HW-1:0]            hw_ready_o,
  input  logic [NUM_HW*DATA_WIDTH-1:0] hw_d_i,
  input  logic [NUM_HW*DATA_WIDTH-1:0] hw_mask_i,
  output logic [DATA_WIDTH-1:0]        q_o,
  output logic                         qe_o,
  output logic                         upd_o
);

  localparam int unsigned RrW = (NUM_HW > 1) ? $clog2(NUM_HW) : 1;

  // Modes where a software write replaces the whole value, so a same-cycle
  // hardware update would be lost; those channels are held off instead.
  localparam logic SwStall = (SwAccess == SwAccessRW) || (SwAccess == SwAccessWO);

  // Modes in which the software strobe has any effect on the field.
  localparam logic SwHasWrite = (SwAccess == SwAccessRW)  || (SwAccess == SwAccessWO)  ||
                                (SwAccess == SwAccessW1S) || (SwAccess == SwAccessW1C) ||
                                (SwAccess == SwAccessW0C) || (SwAccess == SwAccessRC);

  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  qe_q, upd_q;
  logic [RrW-1:0]        rr_q, rr_d;

  logic [NUM_HW-1:0]     grant;
  logic                  found;
  logic [RrW-1:0]        gidx;
  logic [DATA_WIDTH-1:0] sel_d, sel_m;
  int unsigned           idx;

  logic                  stall, de, swa, wr_en;
  logic [DATA_WIDTH-1:0] hw_val, base, wr_data;

  // Round-robin search: first valid channel at or after rr, wrapping at NUM_HW.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    sel_d = '0;
    sel_m = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_HW; i++) begin
      idx = (32'(rr_q) + i) % NUM_HW;
      if (!found && hw_valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx[RrW-1:0];
        sel_d      = hw_d_i[idx*DATA_WIDTH +: DATA_WIDTH];
        sel_m      = hw_mask_i[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign stall      = SwStall & we_i;
  assign hw_ready_o = stall ? '0 : grant;
  assign de         = found & ~stall;
  assign swa        = SwHasWrite & we_i;
  assign wr_en      = swa | de;

  // Masked hardware value: unmasked bits keep the current field value.
  assign hw_val = (sel_m & sel_d) | (~sel_m & q_q);
  assign base   = de ? hw_val : q_q;

  // Next field value per software access policy; software wins on shared bits.
  always_comb begin
    wr_data = hw_val;
    case (SwAccess)
      SwAccessRW, SwAccessWO: wr_data = swa ? wd_i : hw_val;
      SwAccessW1S:            wr_data = base | (swa ? wd_i : '0);
      SwAccessW1C:            wr_data = base & (swa ? ~wd_i : '1);
      SwAccessW0C:            wr_data = base & (swa ? wd_i : '1);
      SwAccessRC:             wr_data = base & (swa ? '0 : '1);
      default:                wr_data = hw_val;
    endcase
  end

  // Field load and round-robin pointer advance past the channel that transferred.
  always_comb begin
    q_d  = wr_en ? wr_data : q_q;
    rr_d = rr_q;
    if (de) begin
      rr_d = (gidx == RrW'(NUM_HW - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= RESVAL;
      qe_q  <= 1'b0;
      upd_q <= 1'b0;
      rr_q  <= '0;
    end else begin
      q_q   <= q_d;
      qe_q  <= swa;
      upd_q <= wr_en;
      rr_q  <= rr_d;
    end
  end

  assign q_o   = q_q;
  assign qe_o  = qe_q;
  assign upd_o = upd_q;

endmodule

// File: tb/tb_iommu_field_reg_mc.sv
// Bench for iommu_field_reg_mc: four instances (RW, W1C, RO, 3-channel RW) driven by directed vectors.
// Expected values are queued against a cycle number; a negedge monitor pops and compares.
// Stimulus changes 1ns after the rising edge; outputs are sampled on the falling edge.

module tb_iommu_field_reg_mc;
  import iommu_field_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RW instance, two channels, non-zero reset value
  logic        rw_we;   logic [31:0] rw_wd;
  logic [1:0]  rw_vld;  logic [1:0]  rw_rdy;
  logic [63:0] rw_d;    logic [63:0] rw_m;
  logic [31:0] rw_q;    logic rw_qe, rw_upd;
  // W1C instance
  logic        c_we;    logic [31:0] c_wd;
  logic [1:0]  c_vld;   logic [1:0]  c_rdy;
  logic [63:0] c_d;     logic [63:0] c_m;
  logic [31:0] c_q;     logic c_qe, c_upd;
  // RO instance
  logic        o_we;    logic [31:0] o_wd;
  logic [1:0]  o_vld;   logic [1:0]  o_rdy;
  logic [63:0] o_d;     logic [63:0] o_m;
  logic [31:0] o_q;     logic o_qe, o_upd;
  // RW instance, three channels
  logic        r_we;    logic [31:0] r_wd;
  logic [2:0]  r_vld;   logic [2:0]  r_rdy;
  logic [95:0] r_d;     logic [95:0] r_m;
  logic [31:0] r_q;     logic r_qe, r_upd;

  iommu_field_reg_mc #(.DATA_WIDTH(32), .NUM_HW(2), .SwAccess(SwAccessRW), .RESVAL(32'hA5A5_0000)) u_rw (
    .clk_i(clk), .rst_ni(rst_n), .we_i(rw_we), .wd_i(rw_wd), .hw_valid_i(rw_vld), .hw_ready_o(rw_rdy),
    .hw_d_i(rw_d), .hw_mask_i(rw_m), .q_o(rw_q), .qe_o(rw_qe), .upd_o(rw_upd));
  iommu_field_reg_mc #(.DATA_WIDTH(32), .NUM_HW(2), .SwAccess(SwAccessW1C), .RESVAL(32'h0000_000F)) u_w1c (
    .clk_i(clk), .rst_ni(rst_n), .we_i(c_we), .wd_i(c_wd), .hw_valid_i(c_vld), .hw_ready_o(c_rdy),
    .hw_d_i(c_d), .hw_mask_i(c_m), .q_o(c_q), .qe_o(c_qe), .upd_o(c_upd));
  iommu_field_reg_mc #(.DATA_WIDTH(32), .NUM_HW(2), .SwAccess(SwAccessRO), .RESVAL(32'h0000_1111)) u_ro (
    .clk_i(clk), .rst_ni(rst_n), .we_i(o_we), .wd_i(o_wd), .hw_valid_i(o_vld), .hw_ready_o(o_rdy),
    .hw_d_i(o_d), .hw_mask_i(o_m), .q_o(o_q), .qe_o(o_qe), .upd_o(o_upd));
  iommu_field_reg_mc #(.DATA_WIDTH(32), .NUM_HW(3), .SwAccess(SwAccessRW), .RESVAL(32'h0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .we_i(r_we), .wd_i(r_wd), .hw_valid_i(r_vld), .hw_ready_o(r_rdy),
    .hw_d_i(r_d), .hw_mask_i(r_m), .q_o(r_q), .qe_o(r_qe), .upd_o(r_upd));

  localparam int RW_Q = 0, RW_QE = 1, RW_UPD = 2, RW_RDY = 3;
  localparam int C_Q = 4, C_RDY = 5;
  localparam int O_Q = 6, O_QE = 7, O_UPD = 8, O_RDY = 9;
  localparam int R_Q = 10, R_RDY = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   errs = 0;
  int   checks = 0;

  function automatic void expect_at(int dc, int sig, logic [31:0] v, string nm);
    exp_t e;
    int   pos;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.val = v;
    e.nm  = nm;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
    sb.insert(pos, e);
  endfunction

  function automatic logic [31:0] act(int s);
    case (s)
      RW_Q:   return rw_q;
      RW_QE:  return 32'(rw_qe);
      RW_UPD: return 32'(rw_upd);
      RW_RDY: return 32'(rw_rdy);
      C_Q:    return c_q;
      C_RDY:  return 32'(c_rdy);
      O_Q:    return o_q;
      O_QE:   return 32'(o_qe);
      O_UPD:  return 32'(o_upd);
      O_RDY:  return 32'(o_rdy);
      R_Q:    return r_q;
      R_RDY:  return 32'(r_rdy);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      checks++;
      if (act(me.sig) !== me.val) begin
        errs++;
        $display("FAIL %s @cyc %0d: got %h want %h", me.nm, cyc, act(me.sig), me.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rw_we = 0; rw_wd = '0; rw_vld = '0; rw_d = '0; rw_m = '0;
    c_we  = 0; c_wd  = '0; c_vld  = '0; c_d  = '0; c_m  = '0;
    o_we  = 0; o_wd  = '0; o_vld  = '0; o_d  = '0; o_m  = '0;
    r_we  = 0; r_wd  = '0; r_vld  = '0; r_d  = '0; r_m  = '0;

    // Reset values
    tick(); tick();
    expect_at(0, RW_Q, 32'hA5A5_0000, "rst_rw_q");
    expect_at(0, RW_QE, 0, "rst_rw_qe");
    expect_at(0, RW_UPD, 0, "rst_rw_upd");
    expect_at(0, RW_RDY, 0, "rst_rw_rdy");
    expect_at(0, C_Q, 32'h0000_000F, "rst_w1c_q");
    expect_at(0, O_Q, 32'h0000_1111, "rst_ro_q");
    expect_at(0, R_RDY, 0, "rst_rr_rdy");
    expect_at(0, R_Q, 0, "rst_rr_q");
    tick();
    rst_n = 1;

    // Masked hardware update on ch0
    tick();
    rw_vld = 2'b01; rw_d = {32'h0, 32'hFFFF_FFFF}; rw_m = {32'h0, 32'h0000_00FF};
    expect_at(0, RW_RDY, 2'b01, "mask_rdy");
    expect_at(1, RW_Q, 32'hA5A5_00FF, "mask_q");
    expect_at(1, RW_UPD, 1, "mask_upd");
    expect_at(1, RW_QE, 0, "mask_qe");
    tick();
    rw_vld = '0;

    // RW stall: software write holds off ch1, which is served next cycle
    tick();
    rw_we = 1; rw_wd = 32'h1234_5678;
    rw_vld = 2'b10; rw_d = {32'hDEAD_BEEF, 32'h0}; rw_m = {32'hFFFF_FFFF, 32'h0};
    expect_at(0, RW_RDY, 0, "stall_rdy0");
    tick();
    rw_we = 0;
    expect_at(0, RW_Q, 32'h1234_5678, "stall_q1");
    expect_at(0, RW_QE, 1, "stall_qe1");
    expect_at(0, RW_RDY, 2'b10, "stall_rdy1");
    expect_at(1, RW_Q, 32'hDEAD_BEEF, "stall_q2");
    expect_at(1, RW_QE, 0, "stall_qe2");
    expect_at(1, RW_UPD, 1, "stall_upd2");
    tick();
    rw_vld = '0;

    // Back-to-back software writes
    tick();
    rw_we = 1; rw_wd = 32'h1;
    tick();
    rw_wd = 32'h2;
    expect_at(0, RW_QE, 1, "b2b_qe1");
    expect_at(0, RW_Q, 32'h1, "b2b_q1");
    tick();
    rw_we = 0;
    expect_at(0, RW_QE, 1, "b2b_qe2");
    expect_at(0, RW_Q, 32'h2, "b2b_q2");
    expect_at(1, RW_QE, 0, "b2b_qe3");
    expect_at(1, RW_UPD, 0, "b2b_upd3");
    expect_at(1, RW_Q, 32'h2, "b2b_q3");
    tick();

    // W1C collision: clear bits 1:0 while ch0 sets bit 8
    tick();
    c_we = 1; c_wd = 32'h0000_0003;
    c_vld = 2'b01; c_d = {32'h0, 32'h0000_010F}; c_m = {32'h0, 32'h0000_0100};
    expect_at(0, C_RDY, 2'b01, "w1c_rdy");
    expect_at(1, C_Q, 32'h0000_010C, "w1c_collide_q");
    tick();
    c_vld = '0; c_wd = 32'h0000_0104;
    expect_at(1, C_Q, 32'h0000_0008, "w1c_clear_q");
    tick();
    c_we = 0;

    // RO: software write ignored, hardware update still applies
    tick();
    o_we = 1; o_wd = 32'hFFFF_FFFF;
    expect_at(1, O_Q, 32'h0000_1111, "ro_q_sw");
    expect_at(1, O_QE, 0, "ro_qe_sw");
    expect_at(1, O_UPD, 0, "ro_upd_sw");
    tick();
    o_vld = 2'b10; o_d = {32'hABCD_0000, 32'h0}; o_m = {32'hFFFF_0000, 32'h0};
    expect_at(0, O_RDY, 2'b10, "ro_rdy");
    expect_at(1, O_Q, 32'hABCD_1111, "ro_q_hw");
    expect_at(1, O_UPD, 1, "ro_upd_hw");
    expect_at(1, O_QE, 0, "ro_qe_hw");
    tick();
    o_we = 0; o_vld = '0;

    // Round-robin over three always-valid channels
    r_d = {32'h33, 32'h22, 32'h11}; r_m = '1;
    tick();
    r_vld = 3'b111;
    expect_at(0, R_RDY, 3'b001, "rr_g0");
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_at(0, R_RDY, 32'(3'b001 << (k % 3)), $sformatf("rr_g%0d", k));
    end
    tick();
    r_vld = 3'b010;
    expect_at(0, R_RDY, 3'b010, "rr_after_ch0");
    expect_at(0, R_Q, 32'h11, "rr_q_ch0");
    tick();
    r_vld = 3'b001;
    expect_at(0, R_RDY, 3'b001, "rr_wrap");
    expect_at(0, R_Q, 32'h22, "rr_q_ch1");
    tick();
    r_vld = '0;
    expect_at(0, R_Q, 32'h11, "rr_q_last");
    expect_at(0, R_RDY, 0, "rr_idle_rdy");

    // Reset asserted mid-cycle while ch0 transfers
    tick();
    rw_vld = 2'b01; rw_d = {32'h0, 32'h0000_0055}; rw_m = {32'h0, 32'hFFFF_FFFF};
    expect_at(0, RW_RDY, 2'b01, "mr_pre_rdy");
    tick();
    #2;
    rst_n = 0;
    expect_at(0, RW_Q, 32'hA5A5_0000, "mr_async_q");
    expect_at(0, RW_UPD, 0, "mr_async_upd");
    expect_at(0, RW_QE, 0, "mr_async_qe");
    tick();
    rst_n = 1;
    rw_vld = 2'b11;
    expect_at(0, RW_Q, 32'hA5A5_0000, "mr_held_q");
    expect_at(0, RW_RDY, 2'b01, "mr_first_grant");
    expect_at(1, RW_Q, 32'h0000_0055, "mr_post_q");
    tick();
    rw_vld = '0;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      errs++;
      checks++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
